counter_arbiter_ctrl: RTL
=========================

# counter_arbiter_ctrl

Controller that shares one 4-bit event counter between two requesters. Each requester asks for a counting session of up to 15 `x` pulses; the block arbitrates round-robin, sequences the counter through clear/count/compare, and returns a one-cycle `done` to the winner. It sits between the two client state machines and the counter datapath, which is contained inside the block.

## Interface
Parameters: none. Counter width is fixed at 4 bits.

Ports:
- `clk` in 1: single system clock, rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `req` in 2: session request, one bit per requester; level-sensitive, held high until `done` or abort.
- `lim0` in 4: target count for requester 0, sampled at grant.
- `lim1` in 4: target count for requester 1, sampled at grant.
- `x` in 1: count-enable pulse input; one increment per cycle while high.
- `grant` out 2: one-hot owner of the counter; `00` when idle.
- `busy` out 1: high in COUNT and DONE.
- `done` out 2: one-cycle completion pulse to the owning requester.
- `en` out 1: counter increment strobe for the current cycle.
- `count` out 4: counter value.

## Operation
- State register, one-hot: IDLE, COUNT, DONE.
- State pointer `last` (1 bit): index of the requester served most recently.
- IDLE:
  - `grant=00`, `busy=0`, `en=0`.
  - `count` holds its last value.
  - If any `req` bit is high, the next edge enters COUNT and performs all of the following:
    - Select the winner. If exactly one `req` bit is high, that requester wins. If both are high, the requester other than `last` wins.
    - Set `grant` one-hot to the winner.
    - Latch the winner's `lim` into internal `lim_q`.
    - Clear `count` to 0.
- COUNT:
  - `en = x & (count != lim_q)`.
  - If `count == lim_q`, the next edge enters DONE and `count` holds.
  - Otherwise `count` increments on each edge where `en=1`.
  - Comparison uses the registered `count`, so `lim=0` completes without any increment.
  - Abort: if the owner's `req` is low in COUNT, the next edge enters IDLE with no `done`. `grant` clears, `last` updates to the owner, and `count` holds.
- DONE:
  - `done[owner]=1` for exactly this cycle.
  - `grant` stays asserted during this cycle.
  - On the next edge: enter IDLE, `last` updates to the owner, `grant=00`.
- No wrap-around: `count` never exceeds `lim_q` (maximum 15), so 15→0 never occurs.
- The non-owner's `req` and `lim` are ignored while `busy`.
- `x` is ignored in IDLE and DONE.

## Timing
- Reset (asynchronous, immediate) sets:
  - state IDLE
  - `grant=00`, `done=00`, `busy=0`, `en=0`
  - `count=0`, `lim_q=0`
  - `last=1`, so requester 0 wins the first contention.
- From the first edge that samples `req` high in IDLE:
  - Grant is visible 1 edge later.
  - With `x` held high, `done` is visible `lim+2` edges later.
  - `done` lasts 1 cycle.
  - IDLE is re-entered 1 edge after `done`.
- Minimum gap between sessions: 1 IDLE cycle. There is no back-to-back grant.
- All outputs are registered except `en`, which is combinational from state, `x`, `count` and `lim_q`.
- `reset` asserted mid-session aborts immediately. No `done` is issued.

## Test plan
- Reset, then hold `req=01`, `lim0=3`, `x=1`. Required response:
  - `grant=01` after edge 1.
  - `count` steps 0,1,2,3 on edges 1–4.
  - `done=01` during the cycle after edge 5.
  - IDLE after edge 6, with `count=3` held.
- Hold `req=11` continuously with `lim0=2`, `lim1=1`, `x=1`. Required response: grants alternate 01, 10, 01, with each `done` matching its grant.
- `req=10`, `lim1=0`. Required response: `grant=10` after edge 1, `done=10` after edge 2, and `count` stays 0.
- `req=01`, `lim0=4`, `x` toggled 1,0,1,0,… Required response:
  - `count` advances only on `x=1` cycles.
  - `en` mirrors `x` until `count=4`.
  - `done` after edge 9.
- `req=01`, `lim0=10`. Drop `req` when `count=5`. Required response:
  - IDLE on the next edge.
  - `done` stays 00, `count=5` held.
  - Then `req=11` grants requester 1.
- Assert `reset` mid-COUNT at `count=6`. Required response:
  - All outputs return to reset values without waiting for a clock edge.
  - Next contention `req=11` grants 01.

Source files
------------

// File: rtl/counter_arbiter_ctrl.sv
// Two-requester round-robin controller around a 4-bit session counter.
// Each session: latch the target, clear, count x pulses up to the target, pulse done.
module counter_arbiter_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [3:0] lim0,
    input  logic [3:0] lim1,
    input  logic       x,
    output logic [1:0] grant,
    output logic       busy,
    output logic [1:0] done,
    output logic       en,
    output logic [3:0] count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_COUNT = 3'b010,
        S_DONE  = 3'b100
    } state_t;

    state_t     state_q, state_d;
    logic       last_q,  last_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] done_q,  done_d;
    logic       busy_q,  busy_d;
    logic [3:0] count_q, count_d;
    logic [3:0] lim_q,   lim_d;

    logic owner;
    logic winner;
    logic at_lim;

    assign owner  = grant_q[1];
    assign at_lim = (count_q == lim_q);
    // Under contention the requester not served last time wins.
    assign winner = (req == 2'b11) ? ~last_q : req[1];
    assign en     = (state_q == S_COUNT) & x & ~at_lim;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        done_d  = 2'b00;
        busy_d  = busy_q;
        count_d = count_q;
        lim_d   = lim_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_COUNT;
                    grant_d = winner ? 2'b10 : 2'b01;
                    lim_d   = winner ? lim1 : lim0;
                    count_d = 4'd0;
                    busy_d  = 1'b1;
                end
            end
            S_COUNT: begin
                // Abort takes priority over completion: a withdrawn request gets no done.
                if (!req[owner]) begin
                    state_d = S_IDLE;
                    grant_d = 2'b00;
                    busy_d  = 1'b0;
                    last_d  = owner;
                end else if (at_lim) begin
                    state_d = S_DONE;
                    done_d  = owner ? 2'b10 : 2'b01;
                end else if (en) begin
                    count_d = count_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
                busy_d  = 1'b0;
                last_d  = owner;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            grant_q <= 2'b00;
            done_q  <= 2'b00;
            busy_q  <= 1'b0;
            count_q <= 4'd0;
            lim_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            count_q <= count_d;
            lim_q   <= lim_d;
        end
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign count = count_q;

endmodule
